// File: rtl/dac_slew_guard_if.sv
// Control/config/status bundle between the PID loop and the DAC conditioning stage.
interface dac_slew_guard_if #(
    parameter int unsigned DAT_W = 14,
    parameter int unsigned CNT_W = 16
);
    logic             enable_i;
    logic [DAT_W-1:0] pid_i;
    logic [DAT_W-1:0] lim_lo_i;
    logic [DAT_W-1:0] lim_hi_i;
    logic [DAT_W-1:0] slew_step_i;
    logic [CNT_W-1:0] slew_div_i;
    logic [CNT_W-1:0] rail_max_i;
    logic             rail_clear_i;
    logic [DAT_W-1:0] code_o;
    logic [DAT_W-1:0] dac_o;
    logic [1:0]       state_o;
    logic             clamped_o;
    logic             railed_o;

    // Master drives control/config, slave (the guard) drives status and DAC word.
    modport master (
        output enable_i, pid_i, lim_lo_i, lim_hi_i, slew_step_i,
               slew_div_i, rail_max_i, rail_clear_i,
        input  code_o, dac_o, state_o, clamped_o, railed_o
    );

    modport slave (
        input  enable_i, pid_i, lim_lo_i, lim_hi_i, slew_step_i,
               slew_div_i, rail_max_i, rail_clear_i,
        output code_o, dac_o, state_o, clamped_o, railed_o
    );
endinterface

// File: rtl/dac_slew_guard.sv
// Clamp, slew-limit and park the PID control word before it reaches the DAC;
// flag sustained rail saturation of the PID output.
module dac_slew_guard #(
    parameter int unsigned DAT_W = 14,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    dac_slew_guard_if.slave  bus
);

    localparam logic [DAT_W-1:0] MID_CODE = {1'b1, {(DAT_W-1){1'b0}}};
    localparam logic [DAT_W-1:0] MAX_CODE = {DAT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PARK = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_n;
    logic [DAT_W-1:0] code_r;
    logic [DAT_W-1:0] code_n;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] rail_cnt_r;
    logic [CNT_W-1:0] rail_cnt_n;
    logic             clamped_r;
    logic             clamped_n;
    logic             railed_r;
    logic             railed_n;

    logic [CNT_W-1:0] div_last;
    logic             tick;
    logic [DAT_W-1:0] win_tgt;
    logic [DAT_W-1:0] run_tgt;
    logic [DAT_W-1:0] tgt;
    logic [DAT_W:0]   diff;
    logic [DAT_W:0]   diff_mag;
    logic             step_ok;
    logic [DAT_W-1:0] slew_code;
    logic             rail_hit;
    logic [CNT_W-1:0] rail_inc;
    logic             rail_set;

    // Last counter value of an update period (divider of 0 behaves as 1).
    assign div_last = (bus.slew_div_i == '0) ? '0 : bus.slew_div_i - CNT_W'(1);
    assign tick     = (state_r != ST_IDLE) && (cnt_r == '0);

    // Window clamp; an inverted window disables clamping.
    always_comb begin
        win_tgt = bus.pid_i;
        if (bus.pid_i < bus.lim_lo_i) begin
            win_tgt = bus.lim_lo_i;
        end else if (bus.pid_i > bus.lim_hi_i) begin
            win_tgt = bus.lim_hi_i;
        end
        run_tgt = (bus.lim_lo_i <= bus.lim_hi_i) ? win_tgt : bus.pid_i;
        tgt     = (state_r == ST_PARK) ? MID_CODE : run_tgt;
    end

    // Slew limiter: step toward target, never overshooting it.
    always_comb begin
        diff     = {1'b0, tgt} - {1'b0, code_r};
        diff_mag = diff[DAT_W] ? ({1'b0, code_r} - {1'b0, tgt}) : diff;
        step_ok  = (bus.slew_step_i == '0) || (diff_mag <= {1'b0, bus.slew_step_i});
        if (step_ok) begin
            slew_code = tgt;
        end else if (diff[DAT_W]) begin
            slew_code = code_r - bus.slew_step_i;
        end else begin
            slew_code = code_r + bus.slew_step_i;
        end
    end

    // Rail detection on the raw PID word; saturating run-length count.
    always_comb begin
        rail_hit = (bus.pid_i == '0) || (bus.pid_i == MAX_CODE);
        rail_inc = (rail_cnt_r == '1) ? rail_cnt_r : rail_cnt_r + CNT_W'(1);
        rail_set = rail_hit && (bus.rail_max_i != '0) && (rail_inc >= bus.rail_max_i);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic; enable takes priority over parking completion.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: if (bus.enable_i) state_n = ST_RUN;
            ST_RUN:  if (!bus.enable_i) state_n = ST_PARK;
            ST_PARK: begin
                if (bus.enable_i) begin
                    state_n = ST_RUN;
                end else if (code_r == MID_CODE) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM output/datapath next values.
    always_comb begin
        code_n     = code_r;
        cnt_n      = cnt_r;
        rail_cnt_n = rail_cnt_r;
        clamped_n  = clamped_r;
        railed_n   = railed_r;

        // Divider restarts on every state change so the first update is immediate.
        if ((state_n == ST_IDLE) || (state_n != state_r) || (cnt_r >= div_last)) begin
            cnt_n = '0;
        end else begin
            cnt_n = cnt_r + CNT_W'(1);
        end

        case (state_r)
            ST_IDLE: begin
                code_n    = MID_CODE;
                clamped_n = 1'b0;
            end
            ST_RUN: begin
                if (tick) begin
                    code_n     = slew_code;
                    clamped_n  = (run_tgt != bus.pid_i);
                    rail_cnt_n = rail_hit ? rail_inc : '0;
                    if (rail_set) railed_n = 1'b1;
                end
            end
            ST_PARK: begin
                if (tick) code_n = slew_code;
            end
            default: code_n = MID_CODE;
        endcase

        if (state_n != ST_RUN) rail_cnt_n = '0;
        if (bus.rail_clear_i) railed_n = 1'b0;
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_r     <= MID_CODE;
            cnt_r      <= '0;
            rail_cnt_r <= '0;
            clamped_r  <= 1'b0;
            railed_r   <= 1'b0;
        end else begin
            code_r     <= code_n;
            cnt_r      <= cnt_n;
            rail_cnt_r <= rail_cnt_n;
            clamped_r  <= clamped_n;
            railed_r   <= railed_n;
        end
    end

    // Offset-binary to two's complement is an MSB inversion.
    assign bus.code_o    = code_r;
    assign bus.dac_o     = {~code_r[DAT_W-1], code_r[DAT_W-2:0]};
    assign bus.state_o   = state_r;
    assign bus.clamped_o = clamped_r;
    assign bus.railed_o  = railed_r;

endmodule

// File: tb/tb_dac_slew_guard.sv
// Directed self-checking bench for dac_slew_guard.
module tb_dac_slew_guard;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dac_slew_guard_if #(.DAT_W(14), .CNT_W(16)) bus ();

    dac_slew_guard #(.DAT_W(14), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        bus.enable_i     = 1'b0;
        bus.pid_i        = 14'd8192;
        bus.lim_lo_i     = 14'd0;
        bus.lim_hi_i     = 14'd16383;
        bus.slew_step_i  = 14'd0;
        bus.slew_div_i   = 16'd1;
        bus.rail_max_i   = 16'd0;
        bus.rail_clear_i = 1'b0;

        // Reset values
        step_clk(2);
        check("rst_code", 32'(bus.code_o), 32'd8192);
        check("rst_dac", 32'(bus.dac_o), 32'h0000);
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_clamped", 32'(bus.clamped_o), 32'd0);
        check("rst_railed", 32'(bus.railed_o), 32'd0);
        rst = 1'b0;

        // Idle stability
        for (int i = 0; i < 100; i++) begin
            step_clk(1);
            check("idle_code", 32'(bus.code_o), 32'd8192);
        end
        check("idle_state", 32'(bus.state_o), 32'd0);

        // Unlimited jump to 10000 two edges after enable
        bus.pid_i    = 14'd10000;
        bus.enable_i = 1'b1;
        step_clk(1);
        check("en_state", 32'(bus.state_o), 32'd1);
        check("en_code_e1", 32'(bus.code_o), 32'd8192);
        step_clk(1);
        check("en_code_e2", 32'(bus.code_o), 32'd10000);
        check("en_dac", 32'(bus.dac_o), 32'h0710);
        check("en_clamped", 32'(bus.clamped_o), 32'd0);

        // Back to midscale, then slew 8192 -> 9000 at 100/update, 4 clocks/update
        bus.pid_i = 14'd8192;
        step_clk(1);
        check("mid_code", 32'(bus.code_o), 32'd8192);
        bus.slew_step_i = 14'd100;
        bus.slew_div_i  = 16'd4;
        bus.pid_i       = 14'd9000;
        step_clk(1);
        check("slew_u1", 32'(bus.code_o), 32'd8292);
        step_clk(3);
        check("slew_hold", 32'(bus.code_o), 32'd8292);
        step_clk(1);
        check("slew_u2", 32'(bus.code_o), 32'd8392);
        step_clk(24);
        check("slew_u8", 32'(bus.code_o), 32'd8992);
        step_clk(3);
        check("slew_u8_hold", 32'(bus.code_o), 32'd8992);
        step_clk(1);
        check("slew_u9", 32'(bus.code_o), 32'd9000);
        check("slew_clamped", 32'(bus.clamped_o), 32'd0);

        // Window clamp, then inverted window disables clamping
        bus.slew_step_i = 14'd0;
        bus.slew_div_i  = 16'd1;
        bus.lim_lo_i    = 14'd8000;
        bus.lim_hi_i    = 14'd8500;
        step_clk(3);
        check("win_code", 32'(bus.code_o), 32'd8500);
        check("win_clamped", 32'(bus.clamped_o), 32'd1);
        bus.lim_lo_i = 14'd9000;
        step_clk(2);
        check("inv_code", 32'(bus.code_o), 32'd9000);
        check("inv_clamped", 32'(bus.clamped_o), 32'd0);

        // Park ramp 9000 -> 8192 at 100/clock, then IDLE
        bus.lim_lo_i    = 14'd0;
        bus.lim_hi_i    = 14'd16383;
        bus.slew_step_i = 14'd100;
        bus.enable_i    = 1'b0;
        step_clk(1);
        check("park_state", 32'(bus.state_o), 32'd2);
        check("park_code0", 32'(bus.code_o), 32'd9000);
        step_clk(1);
        check("park_u1", 32'(bus.code_o), 32'd8900);
        step_clk(7);
        check("park_u8", 32'(bus.code_o), 32'd8200);
        step_clk(1);
        check("park_u9", 32'(bus.code_o), 32'd8192);
        check("park_u9_state", 32'(bus.state_o), 32'd2);
        step_clk(1);
        check("park_idle", 32'(bus.state_o), 32'd0);
        check("park_idle_code", 32'(bus.code_o), 32'd8192);

        // Re-enable mid-ramp resumes from the current code
        bus.slew_step_i = 14'd0;
        bus.enable_i    = 1'b1;
        step_clk(2);
        check("re_run_code", 32'(bus.code_o), 32'd9000);
        bus.slew_step_i = 14'd100;
        bus.enable_i    = 1'b0;
        step_clk(3);
        check("re_park_state", 32'(bus.state_o), 32'd2);
        check("re_park_code", 32'(bus.code_o), 32'd8800);
        bus.enable_i = 1'b1;
        step_clk(1);
        check("re_run_state", 32'(bus.state_o), 32'd1);
        check("re_run_code1", 32'(bus.code_o), 32'd8700);
        step_clk(1);
        check("re_run_code2", 32'(bus.code_o), 32'd8800);

        // Rail detection at the 3rd railed tick
        bus.slew_step_i = 14'd0;
        bus.rail_max_i  = 16'd3;
        bus.pid_i       = 14'd16383;
        step_clk(1);
        check("rail_code", 32'(bus.code_o), 32'd16383);
        check("rail_dac", 32'(bus.dac_o), 32'h1FFF);
        check("rail_t1", 32'(bus.railed_o), 32'd0);
        step_clk(1);
        check("rail_t2", 32'(bus.railed_o), 32'd0);
        step_clk(1);
        check("rail_t3", 32'(bus.railed_o), 32'd1);

        // Clear wins over a same-cycle set; flag re-sets afterwards
        bus.rail_clear_i = 1'b1;
        step_clk(1);
        check("rail_clr_win", 32'(bus.railed_o), 32'd0);
        bus.rail_clear_i = 1'b0;
        step_clk(1);
        check("rail_reset", 32'(bus.railed_o), 32'd1);

        // Detection disabled
        bus.rail_max_i   = 16'd0;
        bus.rail_clear_i = 1'b1;
        step_clk(1);
        bus.rail_clear_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_clk(1);
            check("rail_off", 32'(bus.railed_o), 32'd0);
        end

        // Asynchronous reset mid-ramp returns to midscale immediately
        bus.slew_step_i = 14'd1;
        bus.enable_i    = 1'b0;
        step_clk(3);
        check("ramp_code", 32'(bus.code_o), 32'd16381);
        check("ramp_state", 32'(bus.state_o), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_code", 32'(bus.code_o), 32'd8192);
        check("arst_dac", 32'(bus.dac_o), 32'h0000);
        check("arst_state", 32'(bus.state_o), 32'd0);
        #2;
        rst = 1'b0;
        step_clk(2);
        check("post_rst_code", 32'(bus.code_o), 32'd8192);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
